// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder.
// The state enum, default sizing and byte-lane count live here so every dmem file agrees on them.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEPTH_LOG2_DEF  = 10;
    localparam int WAIT_CYCLES_DEF = 2;
    localparam int NUM_LANES       = 4;

    // A word address hits the array only when every bit above the index field is zero
    function automatic logic in_range(input logic [29:0] word_addr, input int depth_log2);
        return (word_addr >> depth_log2) == 30'd0;
    endfunction

endpackage

// File: rtl/dmem_bram.sv
// Single-port synchronous RAM with per-byte write enables.
// A read returns the word as it was before any same-edge write; contents have no reset.
module dmem_bram
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [NUM_LANES-1:0]  wstrb,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           dout
);

    logic [31:0] mem [0:(1 << DEPTH_LOG2)-1];

    always_ff @(posedge clk) begin
        if (en) begin
            dout <= mem[addr];
            if (we) begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    if (wstrb[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one request at a time, waits a fixed number of cycles,
// then returns a one-cycle data_ok strobe with load data and an out-of-range flag.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2  = DEPTH_LOG2_DEF,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic                 wr,
    input  logic [NUM_LANES-1:0] wstrb,
    input  logic [31:0]          addr,
    input  logic [31:0]          wdata,
    output logic                 addr_ok,
    output logic                 data_ok,
    output logic [31:0]          rdata,
    output logic                 err
);

    state_t               state, state_next;
    logic [3:0]           cnt, cnt_next;
    logic                 addr_ok_next, data_ok_next, err_next;
    logic [31:0]          rdata_next;
    logic                 accept, bram_en;

    logic [29:0]          lat_addr;
    logic                 lat_wr;
    logic [NUM_LANES-1:0] lat_wstrb;
    logic [31:0]          lat_wdata;

    logic [29:0]          mem_addr;
    logic                 mem_wr, mem_we;
    logic [NUM_LANES-1:0] mem_wstrb;
    logic [31:0]          mem_wdata, mem_dout;
    logic                 unused_addr_lsbs;

    assign unused_addr_lsbs = ^addr[1:0];

    // In IDLE the array sees the live bus so a zero-wait access can use it on the accept edge
    always_comb begin
        if (state == IDLE) begin
            mem_addr  = addr[31:2];
            mem_wr    = wr;
            mem_wstrb = wstrb;
            mem_wdata = wdata;
        end else begin
            mem_addr  = lat_addr;
            mem_wr    = lat_wr;
            mem_wstrb = lat_wstrb;
            mem_wdata = lat_wdata;
        end
    end

    assign mem_we = mem_wr && in_range(mem_addr, DEPTH_LOG2);

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        addr_ok_next = addr_ok;
        data_ok_next = data_ok;
        rdata_next   = rdata;
        err_next     = err;
        accept       = 1'b0;
        bram_en      = 1'b0;
        case (state)
            IDLE: begin
                if (data_ok) begin
                    data_ok_next = 1'b0;
                    rdata_next   = 32'd0;
                    err_next     = 1'b0;
                    addr_ok_next = 1'b1;
                end else if (!addr_ok) begin
                    addr_ok_next = 1'b1;
                end else if (req) begin
                    accept       = 1'b1;
                    addr_ok_next = 1'b0;
                    if (WAIT_CYCLES == 0) begin
                        state_next = RESP;
                        bram_en    = 1'b1;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = 4'(WAIT_CYCLES);
                    end
                end
            end
            WAIT: begin
                cnt_next = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_next = RESP;
                    bram_en    = 1'b1;
                end
            end
            RESP: begin
                // The array word read on the entry edge becomes the registered response here
                state_next   = IDLE;
                data_ok_next = 1'b1;
                err_next     = !in_range(lat_addr, DEPTH_LOG2);
                rdata_next   = (lat_wr || !in_range(lat_addr, DEPTH_LOG2)) ? 32'd0 : mem_dout;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            addr_ok <= 1'b0;
            data_ok <= 1'b0;
            rdata   <= 32'd0;
            err     <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            addr_ok <= addr_ok_next;
            data_ok <= data_ok_next;
            rdata   <= rdata_next;
            err     <= err_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_addr  <= 30'd0;
            lat_wr    <= 1'b0;
            lat_wstrb <= '0;
            lat_wdata <= 32'd0;
        end else if (accept) begin
            lat_addr  <= addr[31:2];
            lat_wr    <= wr;
            lat_wstrb <= wstrb;
            lat_wdata <= wdata;
        end
    end

    dmem_bram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_bram (
        .clk   (clk),
        .en    (bram_en),
        .we    (mem_we),
        .wstrb (mem_wstrb),
        .addr  (mem_addr[DEPTH_LOG2-1:0]),
        .wdata (mem_wdata),
        .dout  (mem_dout)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a 2-wait-state and a 0-wait-state instance share one bus,
// directed scenarios plus random traffic are compared against a word-array reference model.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, wr, sel;
    logic [3:0]  wstrb;
    logic [31:0] addr, wdata;

    logic        req2, addr_ok2, data_ok2, err2;
    logic [31:0] rdata2;
    logic        req0, addr_ok0, data_ok0, err0;
    logic [31:0] rdata0;

    logic        addr_ok_v, data_ok_v, err_v;
    logic [31:0] rdata_v;

    int checks = 0;
    int errors = 0;

    // Reference memory: [instance][word index], only the first 16 words are ever used in range
    logic [31:0] model [0:1][0:15];

    assign req2      = req & ~sel;
    assign req0      = req & sel;
    assign addr_ok_v = sel ? addr_ok0 : addr_ok2;
    assign data_ok_v = sel ? data_ok0 : data_ok2;
    assign err_v     = sel ? err0 : err2;
    assign rdata_v   = sel ? rdata0 : rdata2;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .req(req2), .wr(wr), .wstrb(wstrb), .addr(addr), .wdata(wdata),
        .addr_ok(addr_ok2), .data_ok(data_ok2), .rdata(rdata2), .err(err2)
    );

    dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .wr(wr), .wstrb(wstrb), .addr(addr), .wdata(wdata),
        .addr_ok(addr_ok0), .data_ok(data_ok0), .rdata(rdata0), .err(err0)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drives a request from a falling edge and returns on the falling edge just after it is accepted
    task automatic applyStimulus(input logic s, input logic w, input logic [3:0] st,
                                 input logic [31:0] a, input logic [31:0] d, output int waits);
        sel = s; wr = w; wstrb = st; addr = a; wdata = d; req = 1'b1;
        waits = 0;
        while (addr_ok_v !== 1'b1 && waits < 40) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 40) checkOutput("accept_timeout", 32'(addr_ok_v), 32'd1);
        @(negedge clk);
        req = 1'b0;
        checkOutput("addr_ok_after_accept", 32'(addr_ok_v), 32'd0);
    endtask

    task automatic checkResponse(input string tag, input int lat_exp,
                                 input logic [31:0] rd_exp, input logic err_exp);
        int k = 0;
        while (data_ok_v !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        checkOutput({tag, "_latency"}, 32'(k), 32'(lat_exp));
        checkOutput({tag, "_rdata"}, rdata_v, rd_exp);
        checkOutput({tag, "_err"}, 32'(err_v), 32'(err_exp));
        @(negedge clk);
        checkOutput({tag, "_strobe_width"}, 32'(data_ok_v), 32'd0);
        checkOutput({tag, "_rdata_clear"}, rdata_v, 32'd0);
        checkOutput({tag, "_addr_ok_back"}, 32'(addr_ok_v), 32'd1);
    endtask

    task automatic transact(input string tag, input logic s, input logic w, input logic [3:0] st,
                            input logic [31:0] a, input logic [31:0] d);
        int          waits;
        int          idx;
        logic        oor;
        logic [31:0] exp;
        oor = (a >= 32'd4096);
        idx = int'(a / 32'd4);
        exp = 32'd0;
        if (!w && !oor) exp = model[s][idx];
        applyStimulus(s, w, st, a, d, waits);
        checkResponse(tag, s ? 1 : 3, exp, oor);
        if (w && !oor) begin
            for (int i = 0; i < 4; i++) begin
                if (st[i]) model[s][idx][8*i +: 8] = d[8*i +: 8];
            end
        end
    endtask

    // Holds a load request high and measures the spacing of successive accepts
    task automatic backToBack(input logic s, input int gap_exp);
        int acc [0:2];
        int n   = 0;
        int cyc = 0;
        acc[0] = 0; acc[1] = 0; acc[2] = 0;
        sel = s; wr = 1'b0; wstrb = 4'h0; addr = 32'h10; wdata = 32'd0; req = 1'b1;
        while (cyc < 60) begin
            if (data_ok_v === 1'b1) begin
                checkOutput($sformatf("b2b%0d_rdata", s), rdata_v, model[s][4]);
                checkOutput($sformatf("b2b%0d_busy_during_resp", s), 32'(addr_ok_v), 32'd0);
            end
            if (addr_ok_v === 1'b1) begin
                acc[n] = cyc;
                n++;
            end
            @(negedge clk);
            cyc++;
            if (n == 3) break;
        end
        req = 1'b0;
        checkOutput($sformatf("b2b%0d_accepts", s), 32'(n), 32'd3);
        checkOutput($sformatf("b2b%0d_gap1", s), 32'(acc[1] - acc[0]), 32'(gap_exp));
        checkOutput($sformatf("b2b%0d_gap2", s), 32'(acc[2] - acc[1]), 32'(gap_exp));
        checkResponse($sformatf("b2b%0d_last", s), gap_exp - 2, model[s][4], 1'b0);
    endtask

    initial begin
        int          waits;
        logic        s, w;
        logic [3:0]  st;
        logic [31:0] a, d;

        rst = 1'b1; sel = 1'b0; req = 1'b1; wr = 1'b1; wstrb = 4'hF;
        addr = 32'h10; wdata = 32'hAABBCCDD;
        #12;
        checkOutput("reset_addr_ok", 32'(addr_ok2), 32'd0);
        checkOutput("reset_data_ok", 32'(data_ok2), 32'd0);
        checkOutput("reset_rdata", rdata2, 32'd0);
        checkOutput("reset_err", 32'(err2), 32'd0);
        checkOutput("reset_addr_ok0", 32'(addr_ok0), 32'd0);

        // Release reset with req already high: first cycle must not accept
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("first_cycle_addr_ok", 32'(addr_ok_v), 32'd0);
        applyStimulus(1'b0, 1'b1, 4'hF, 32'h10, 32'hAABBCCDD, waits);
        checkOutput("first_accept_delay", 32'(waits), 32'd1);
        checkResponse("rst_release", 3, 32'd0, 1'b0);
        model[0][4] = 32'hAABBCCDD;

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 2; j++) begin
                if (!(j == 0 && i == 4)) transact("init", 1'(j), 1'b1, 4'hF, 32'(i * 4), $urandom);
            end
        end

        transact("partial_store", 1'b0, 1'b1, 4'b0101, 32'h10, 32'h11223344);
        transact("partial_load", 1'b0, 1'b0, 4'h0, 32'h10, 32'd0);
        checkOutput("partial_model", model[0][4], 32'hAA22CC44);

        transact("idx0_store", 1'b0, 1'b1, 4'hF, 32'h0, 32'hDEADBEEF);
        transact("oor_store", 1'b0, 1'b1, 4'hF, 32'h1000, 32'h12345678);
        transact("oor_load", 1'b0, 1'b0, 4'h0, 32'h1000, 32'd0);
        transact("idx0_load", 1'b0, 1'b0, 4'h0, 32'h0, 32'd0);

        transact("nostrb_store", 1'b0, 1'b1, 4'h0, 32'h10, 32'hFFFFFFFF);
        transact("nostrb_load", 1'b0, 1'b0, 4'h0, 32'h12, 32'd0);

        backToBack(1'b0, 5);
        backToBack(1'b1, 3);

        // Abort a pending store by resetting while it waits
        transact("abort_pre", 1'b0, 1'b1, 4'hF, 32'h20, 32'hCAFEF00D);
        applyStimulus(1'b0, 1'b1, 4'b0001, 32'h20, 32'h00000055, waits);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("abort_addr_ok", 32'(addr_ok_v), 32'd0);
        checkOutput("abort_data_ok", 32'(data_ok_v), 32'd0);
        repeat (2) begin
            @(negedge clk);
            checkOutput("abort_in_reset_data_ok", 32'(data_ok_v), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            checkOutput("abort_no_response", 32'(data_ok_v), 32'd0);
        end
        transact("abort_load", 1'b0, 1'b0, 4'h0, 32'h20, 32'd0);

        for (int i = 0; i < 40; i++) begin
            s  = 1'($urandom_range(0, 1));
            w  = 1'($urandom_range(0, 1));
            st = 4'($urandom);
            d  = $urandom;
            if ($urandom_range(0, 7) == 0)
                a = 32'($urandom_range(1, 1000)) * 32'd4096 + 32'($urandom_range(0, 4095));
            else
                a = 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(0, 3));
            transact($sformatf("rand%0d", i), s, w, st, a, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] simulation timed out");
    end

endmodule
